// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID.
// Holds {pc, inst} pairs in a circular buffer. IF pushes up to FETCH_N
// sequential instructions per cycle. ID sees up to ISSUE_N of the oldest
// entries and consumes out_pop of them per cycle.
module inst_fetch_queue #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [$clog2(FETCH_N+1)-1:0]   in_cnt,
  input  logic [PC_W-1:0]                in_pc,
  input  logic [FETCH_N*DATA_W-1:0]      in_inst,
  output logic                           in_ready,
  output logic                           stallreq_for_fifo,
  output logic [ISSUE_N-1:0]             out_valid,
  output logic [$clog2(ISSUE_N+1)-1:0]   out_cnt,
  output logic [ISSUE_N*DATA_W-1:0]      out_inst,
  output logic [ISSUE_N*PC_W-1:0]        out_pc,
  input  logic [$clog2(ISSUE_N+1)-1:0]   out_pop,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IC_W  = $clog2(FETCH_N+1);
  localparam int OC_W  = $clog2(ISSUE_N+1);

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              cnt_ok;
  logic              push_ok;
  logic              pop_ok;
  logic              proto_err;
  logic [CNT_W-1:0]  push_amt;
  logic [CNT_W-1:0]  pop_amt;

  // Status flags derived from the registered occupancy only (no pop-to-push path)
  always_comb begin
    in_ready          = (count <= CNT_W'(DEPTH - FETCH_N));
    stallreq_for_fifo = ~in_ready;
    full              = (count == CNT_W'(DEPTH));
    empty             = (count == '0);
    out_cnt           = (count >= CNT_W'(ISSUE_N)) ? OC_W'(ISSUE_N) : OC_W'(count);
  end

  // Accept/reject decisions for this cycle's push and pop; flush masks everything
  always_comb begin
    cnt_ok    = (in_cnt != '0) && (in_cnt <= IC_W'(FETCH_N));
    push_ok   = in_valid & in_ready & ~flush & cnt_ok;
    pop_ok    = ~flush & (out_pop <= out_cnt);
    proto_err = ~flush & ((in_valid & (~in_ready | ~cnt_ok)) | (out_pop > out_cnt));
    push_amt  = push_ok ? CNT_W'(in_cnt)  : '0;
    pop_amt   = pop_ok  ? CNT_W'(out_pop) : '0;
  end

  // Pointer, occupancy and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PTR_W'(pop_amt);
        tail  <= tail + PTR_W'(push_amt);
        count <= count + push_amt - pop_amt;
      end
      if (proto_err) begin
        err <= 1'b1;
      end
    end
  end

  // Storage write; left unreset since every read is qualified by count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < FETCH_N; i++) begin
        if (IC_W'(i) < in_cnt) begin
          mem_inst[tail + PTR_W'(i)] <= in_inst[i*DATA_W +: DATA_W];
          mem_pc[tail + PTR_W'(i)]   <= in_pc + PC_W'(4*i);
        end
      end
    end
  end

  // Oldest-first issue window, zeroed beyond out_cnt
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int unsigned i = 0; i < ISSUE_N; i++) begin
      if (OC_W'(i) < out_cnt) begin
        out_valid[i]                 = 1'b1;
        out_inst[i*DATA_W +: DATA_W] = mem_inst[head + PTR_W'(i)];
        out_pc[i*PC_W +: PC_W]       = mem_pc[head + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=8, FETCH_N=2, ISSUE_N=2).
// Reference model: a queue of {pc, inst} entries plus a sticky error bit.
module tb_inst_fetch_queue;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int FETCH_N = 2;
  localparam int ISSUE_N = 2;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_cnt = '0;
  logic [31:0] in_pc = '0;
  logic [63:0] in_inst = '0;
  logic [1:0]  out_pop = '0;
  logic        in_ready;
  logic        stallreq_for_fifo;
  logic [1:0]  out_valid;
  logic [1:0]  out_cnt;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  bit   m_err = 1'b0;

  inst_fetch_queue #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .FETCH_N(FETCH_N),
    .ISSUE_N(ISSUE_N),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_cnt           (in_cnt),
    .in_pc            (in_pc),
    .in_inst          (in_inst),
    .in_ready         (in_ready),
    .stallreq_for_fifo(stallreq_for_fifo),
    .out_valid        (out_valid),
    .out_cnt          (out_cnt),
    .out_inst         (out_inst),
    .out_pc           (out_pc),
    .out_pop          (out_pop),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
    end
  endtask

  // Compare every DUT output against the queue model
  task automatic check_all(input string tag);
    int n;
    int oc;
    logic [63:0] ei;
    logic [63:0] ep;
    logic [1:0]  ev;
    n  = mq.size();
    oc = (n < ISSUE_N) ? n : ISSUE_N;
    ei = '0;
    ep = '0;
    ev = '0;
    for (int i = 0; i < oc; i++) begin
      ei[i*32 +: 32] = mq[i].inst;
      ep[i*32 +: 32] = mq[i].pc;
      ev[i]          = 1'b1;
    end
    check(tag, "count",     64'(count),             64'(n));
    check(tag, "out_cnt",   64'(out_cnt),           64'(oc));
    check(tag, "out_valid", 64'(out_valid),         64'(ev));
    check(tag, "out_inst",  out_inst,               ei);
    check(tag, "out_pc",    out_pc,                 ep);
    check(tag, "in_ready",  64'(in_ready),          64'((DEPTH - n) >= FETCH_N));
    check(tag, "stallreq",  64'(stallreq_for_fifo), 64'((DEPTH - n) < FETCH_N));
    check(tag, "full",      64'(full),              64'(n == DEPTH));
    check(tag, "empty",     64'(empty),             64'(n == 0));
    check(tag, "err",       64'(err),               64'(m_err));
  endtask

  // Advance one clock with the current inputs and apply the same cycle to the model
  task automatic tick();
    int   n;
    int   oc;
    bit   rdy;
    bit   cnt_ok;
    bit   do_push;
    bit   do_pop;
    ent_t e;
    n       = mq.size();
    oc      = (n < ISSUE_N) ? n : ISSUE_N;
    rdy     = (DEPTH - n) >= FETCH_N;
    cnt_ok  = (in_cnt >= 1) && (in_cnt <= FETCH_N);
    do_push = in_valid && rdy && cnt_ok && !flush;
    do_pop  = !flush && (int'(out_pop) <= oc);
    if (!flush && ((in_valid && (!rdy || !cnt_ok)) || (int'(out_pop) > oc))) m_err = 1'b1;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) repeat (out_pop) void'(mq.pop_front());
      if (do_push) begin
        for (int i = 0; i < int'(in_cnt); i++) begin
          e.pc   = in_pc + 32'(4*i);
          e.inst = in_inst[i*32 +: 32];
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] cnt, input logic [31:0] pc,
                      input logic [63:0] inst, input logic [1:0] pop, input logic fl);
    in_valid = v;
    in_cnt   = cnt;
    in_pc    = pc;
    in_inst  = inst;
    out_pop  = pop;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    out_pop  = '0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    mq.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2;
    check_all("reset");
    check("reset", "out_pc_zero", out_pc, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: first fetch group becomes visible one cycle later
    step(1'b1, 2'd2, 32'hBFC00000, {32'h24090002, 32'h24080001}, 2'd0, 1'b0);
    check_all("t1");
    check("t1", "out_cnt",  64'(out_cnt),      64'd2);
    check("t1", "out_pc0",  64'(out_pc[31:0]),  64'hBFC00000);
    check("t1", "out_pc1",  64'(out_pc[63:32]), 64'hBFC00004);
    check("t1", "out_ins0", 64'(out_inst[31:0]), 64'h24080001);
    check("t1", "count",    64'(count),         64'd2);

    // 2: fill to DEPTH, then overflow push is rejected
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 2'd2, 32'hBFC00000 + 32'(8*k), {32'h1000 + 32'(k), 32'h2000 + 32'(k)}, 2'd0, 1'b0);
      check_all("t2fill");
    end
    check("t2", "count",    64'(count),             64'd8);
    check("t2", "full",     64'(full),              64'd1);
    check("t2", "in_ready", 64'(in_ready),          64'd0);
    check("t2", "stallreq", 64'(stallreq_for_fifo), 64'd1);
    step(1'b1, 2'd2, 32'h12345678, 64'hDEADBEEF_CAFEF00D, 2'd0, 1'b0);
    check_all("t2ovf");
    check("t2ovf", "err",     64'(err),           64'd1);
    check("t2ovf", "count",   64'(count),         64'd8);
    check("t2ovf", "out_pc0", 64'(out_pc[31:0]),  64'hBFC00000);

    // 3: simultaneous push/pop at 6, then blocked push at 7
    do_reset();
    check_all("t3rst");
    for (int k = 0; k < 3; k++) step(1'b1, 2'd2, 32'h100 + 32'(8*k), {32'hA0 + 32'(k), 32'hB0 + 32'(k)}, 2'd0, 1'b0);
    check("t3", "count6", 64'(count), 64'd6);
    step(1'b1, 2'd2, 32'h118, 64'h0000_00C1_0000_00C0, 2'd2, 1'b0);
    check_all("t3pp");
    check("t3pp", "count",    64'(count),          64'd6);
    check("t3pp", "in_ready", 64'(in_ready),       64'd1);
    check("t3pp", "out_pc0",  64'(out_pc[31:0]),   64'h108);
    step(1'b1, 2'd1, 32'h120, 64'h0000_0000_0000_00D0, 2'd0, 1'b0);
    check("t3", "count7",   64'(count),    64'd7);
    check("t3", "ready7",   64'(in_ready), 64'd0);
    step(1'b1, 2'd2, 32'h124, 64'h0000_00E1_0000_00E0, 2'd2, 1'b0);
    check_all("t3blk");
    check("t3blk", "count",   64'(count),         64'd5);
    check("t3blk", "err",     64'(err),           64'd1);
    check("t3blk", "out_pc0", 64'(out_pc[31:0]),  64'h110);

    // 4: random legal traffic against the model
    do_reset();
    for (int c = 0; c < 200; c++) begin
      int n;
      int oc;
      n  = mq.size();
      oc = (n < ISSUE_N) ? n : ISSUE_N;
      in_valid = ($urandom_range(7) != 0) && ((DEPTH - n) >= FETCH_N);
      in_cnt   = 2'($urandom_range(2, 1));
      in_pc    = $urandom;
      in_inst  = {$urandom, $urandom};
      out_pop  = ($urandom_range(3) != 0) ? 2'(oc) : 2'($urandom_range(oc, 0));
      tick();
      check_all("t4");
    end
    in_valid = 1'b0;
    out_pop  = '0;
    check("t4", "err_clear", 64'(err), 64'd0);

    // 5: flush beats a same-cycle push and pop
    step(1'b0, 2'd0, 32'h0, 64'h0, 2'd0, 1'b1);
    step(1'b1, 2'd2, 32'h200, 64'h0000_0011_0000_0010, 2'd0, 1'b0);
    step(1'b1, 2'd2, 32'h208, 64'h0000_0013_0000_0012, 2'd0, 1'b0);
    step(1'b1, 2'd1, 32'h210, 64'h0000_0000_0000_0014, 2'd0, 1'b0);
    check("t5", "count5", 64'(count), 64'd5);
    step(1'b1, 2'd2, 32'h300, 64'h0000_0021_0000_0020, 2'd2, 1'b1);
    check_all("t5fl");
    check("t5fl", "count", 64'(count), 64'd0);
    check("t5fl", "empty", 64'(empty), 64'd1);
    step(1'b1, 2'd1, 32'h80000000, 64'h0000_0000_3C1D_8000, 2'd0, 1'b0);
    check_all("t5push");
    check("t5push", "out_pc0", 64'(out_pc[31:0]), 64'h80000000);

    // 6: PC wrap across 2^32, then asynchronous reset mid-cycle
    step(1'b1, 2'd2, 32'hFFFFFFFC, 64'h0000_0031_0000_0030, 2'd1, 1'b0);
    check_all("t6wrap");
    check("t6wrap", "out_pc0", 64'(out_pc[31:0]),  64'hFFFFFFFC);
    check("t6wrap", "out_pc1", 64'(out_pc[63:32]), 64'h00000000);
    check("t6wrap", "valid",   64'(out_valid),     64'd3);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    m_err = 1'b0;
    check_all("t6rst");
    check("t6rst", "out_inst", out_inst, 64'h0);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
